// File: rtl/matrix_scan_ctrl_pkg.sv
// Shared types and constants for the LED matrix row-scan controller.
package matrix_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    LATCH
  } scan_state_t;

  // Counter width able to hold values 0..max_val-1 (never narrower than 1).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

  localparam int unsigned N_ROWS_DEF = 16;
  localparam int unsigned N_COLS_DEF = 16;
  localparam int unsigned ROW_W      = cnt_w(N_ROWS_DEF);
  localparam int unsigned BIT_W      = cnt_w(N_COLS_DEF + 1);

  // ARDUINO_IO pin mapping of the four '595 control lines.
  localparam int unsigned PIN_SER_DATA = 9;
  localparam int unsigned PIN_SER_SEL  = 10;
  localparam int unsigned PIN_SRCLK    = 11;
  localparam int unsigned PIN_RCLK     = 12;

endpackage

// File: rtl/matrix_scan_ctrl_if.sv
// Frame-buffer read port plus the serial '595 pin bundle.
interface matrix_scan_ctrl_if
  import matrix_scan_ctrl_pkg::*;
#(
  parameter int unsigned N_ROWS = N_ROWS_DEF,
  parameter int unsigned N_COLS = N_COLS_DEF
);
  localparam int unsigned ADDR_W = cnt_w(N_ROWS);

  logic [ADDR_W-1:0] rd_addr;
  logic [N_COLS-1:0] rd_data;
  logic              ser_data;
  logic              ser_sel;
  logic              srclk;
  logic              rclk;

  modport master (
    output rd_addr, ser_data, ser_sel, srclk, rclk,
    input  rd_data
  );

  modport slave (
    input  rd_addr, ser_data, ser_sel, srclk, rclk,
    output rd_data
  );
endinterface

// File: rtl/matrix_scan_ctrl_hc595_shifter.sv
// Twin parallel shift registers with shared SRCLK generation, MSB first.
module matrix_scan_ctrl_hc595_shifter
  import matrix_scan_ctrl_pkg::*;
#(
  parameter int unsigned N_COLS = 16,
  parameter int unsigned DIV    = 25
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load_i,
  input  logic [N_COLS-1:0] data_i,
  input  logic [N_COLS-1:0] sel_i,
  output logic              ser_data_o,
  output logic              ser_sel_o,
  output logic              srclk_o,
  output logic              done_c
);
  localparam int unsigned BW = cnt_w(N_COLS + 1);
  localparam int unsigned TW = cnt_w(DIV);

  logic [N_COLS-1:0] data_sr_q, data_sr_d;
  logic [N_COLS-1:0] sel_sr_q, sel_sr_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]     div_cnt_q, div_cnt_d;
  logic              phase_q, phase_d;
  logic              active_q, active_d;
  logic              half_end_c;
  logic              last_bit_c;

  assign half_end_c = active_q && (div_cnt_q == TW'(DIV - 1));
  assign last_bit_c = (bit_cnt_q == BW'(N_COLS - 1));
  assign done_c     = half_end_c && phase_q && last_bit_c;

  // Registers shift in zeros, so the serial lines idle low once a row is out.
  assign ser_data_o = data_sr_q[N_COLS-1];
  assign ser_sel_o  = sel_sr_q[N_COLS-1];
  assign srclk_o    = phase_q;

  // Half-period timer, SRCLK phase and shift-on-falling-edge.
  always_comb begin
    data_sr_d = data_sr_q;
    sel_sr_d  = sel_sr_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    phase_d   = phase_q;
    active_d  = active_q;
    if (load_i) begin
      data_sr_d = data_i;
      sel_sr_d  = sel_i;
      bit_cnt_d = '0;
      div_cnt_d = '0;
      phase_d   = 1'b0;
      active_d  = 1'b1;
    end else if (active_q) begin
      if (half_end_c) begin
        div_cnt_d = '0;
        phase_d   = ~phase_q;
        if (phase_q) begin
          data_sr_d = {data_sr_q[N_COLS-2:0], 1'b0};
          sel_sr_d  = {sel_sr_q[N_COLS-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (last_bit_c) active_d = 1'b0;
        end
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      data_sr_q <= '0;
      sel_sr_q  <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      phase_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      data_sr_q <= data_sr_d;
      sel_sr_q  <= sel_sr_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      phase_q   <= phase_d;
      active_q  <= active_d;
    end
  end
endmodule

// File: rtl/matrix_scan_ctrl.sv
// Row-scan controller: fetch row word, shift pixel+select words, latch with RCLK.
module matrix_scan_ctrl
  import matrix_scan_ctrl_pkg::*;
#(
  parameter int unsigned N_ROWS         = 16,
  parameter int unsigned N_COLS         = 16,
  parameter int unsigned DIV            = 25,
  parameter bit          SEL_ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               en,
  input  logic               row_tick,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun,
  matrix_scan_ctrl_if.master bus
);
  localparam int unsigned ADDR_W = cnt_w(N_ROWS);
  localparam int unsigned TMR_W  = cnt_w(DIV);

  scan_state_t       state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [TMR_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic              rclk_q, rclk_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q;
  logic              tick_c, load_c, shift_done_c;
  logic [N_COLS-1:0] sel_word_c;

  assign tick_c     = row_tick && en;
  assign sel_word_c = (N_COLS'(1) << row_q) ^ {N_COLS{SEL_ACTIVE_LOW}};

  assign bus.rd_addr = row_q;
  assign bus.rclk    = rclk_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign overrun     = overrun_q;

  matrix_scan_ctrl_hc595_shifter #(
    .N_COLS (N_COLS),
    .DIV    (DIV)
  ) u_shifter (
    .clk        (clk),
    .clr        (clr),
    .load_i     (load_c),
    .data_i     (bus.rd_data),
    .sel_i      (sel_word_c),
    .ser_data_o (bus.ser_data),
    .ser_sel_o  (bus.ser_sel),
    .srclk_o    (bus.srclk),
    .done_c     (shift_done_c)
  );

  // Scan sequencing, RCLK timing and tick bookkeeping.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    lat_cnt_d    = lat_cnt_q;
    pending_d    = pending_q;
    overrun_d    = overrun_q;
    rclk_d       = rclk_q;
    frame_done_d = 1'b0;
    load_c       = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick_c || pending_q) begin
          state_d   = FETCH;
          // A fresh tick arriving while a pending one starts stays queued.
          pending_d = pending_q && tick_c;
        end
      end
      FETCH: begin
        load_c  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (shift_done_c) begin
          state_d   = LATCH;
          rclk_d    = 1'b1;
          lat_cnt_d = '0;
        end
      end
      LATCH: begin
        if (lat_cnt_q == TMR_W'(DIV - 1)) begin
          rclk_d  = 1'b0;
          state_d = IDLE;
          if (row_q == ADDR_W'(N_ROWS - 1)) begin
            row_d        = '0;
            frame_done_d = 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if ((state_q != IDLE) && tick_c) begin
      if (!pending_q) pending_d = 1'b1;
      else            overrun_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= IDLE;
      row_q        <= '0;
      lat_cnt_q    <= '0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      rclk_q       <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      lat_cnt_q    <= lat_cnt_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      rclk_q       <= rclk_d;
      frame_done_q <= frame_done_d;
      busy_q       <= (state_d != IDLE);
    end
  end
endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Directed bench for matrix_scan_ctrl (DIV=2); dut1 has an active-low row select.
module tb_matrix_scan_ctrl;
  logic clk = 1'b0;
  logic clr0, clr1, en, tick, mon1;
  logic busy0, busy1, fd0, fd1, ovr0, ovr1;
  logic [15:0] mem [16];

  int n_checks = 0;
  int n_errors = 0;

  int          r_rise, r_rclk, r_fd, r_cyc;
  logic [15:0] r_data, r_sel;
  logic [3:0]  r_addr;
  logic        r_b1;

  always #5 clk = ~clk;

  matrix_scan_ctrl_if #(.N_ROWS(16), .N_COLS(16)) bus0 ();
  matrix_scan_ctrl_if #(.N_ROWS(16), .N_COLS(16)) bus1 ();

  matrix_scan_ctrl #(.N_ROWS(16), .N_COLS(16), .DIV(2), .SEL_ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .clr(clr0), .en(en), .row_tick(tick && !mon1),
    .busy(busy0), .frame_done(fd0), .overrun(ovr0), .bus(bus0)
  );

  matrix_scan_ctrl #(.N_ROWS(16), .N_COLS(16), .DIV(2), .SEL_ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .clr(clr1), .en(en), .row_tick(tick && mon1),
    .busy(busy1), .frame_done(fd1), .overrun(ovr1), .bus(bus1)
  );

  // Synchronous frame-buffer reads: data valid the cycle after the address.
  always @(posedge clk) begin
    bus0.rd_data <= mem[bus0.rd_addr];
    bus1.rd_data <= mem[bus1.rd_addr];
  end

  wire       m_busy  = mon1 ? busy1 : busy0;
  wire       m_srclk = mon1 ? bus1.srclk : bus0.srclk;
  wire       m_rclk  = mon1 ? bus1.rclk : bus0.rclk;
  wire       m_data  = mon1 ? bus1.ser_data : bus0.ser_data;
  wire       m_sel   = mon1 ? bus1.ser_sel : bus0.ser_sel;
  wire       m_fd    = mon1 ? fd1 : fd0;
  wire [3:0] m_addr  = mon1 ? bus1.rd_addr : bus0.rd_addr;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic do_clr();
    @(negedge clk);
    if (mon1) clr1 = 1'b1; else clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    if (mon1) clr1 = 1'b0;
  endtask

  // Optionally tick, then observe one row until busy drops; extra ticks at
  // cycles t2/t3 and en deassertion at cycle en_off (0 = never).
  task automatic run_row(input bit do_tick, input int t2, input int t3, input int en_off);
    logic prev;
    r_rise = 0; r_rclk = 0; r_fd = 0; r_data = '0; r_sel = '0;
    if (do_tick) begin
      @(negedge clk);
      tick = 1'b1;
    end
    @(negedge clk);
    tick  = 1'b0;
    r_cyc = 1;
    r_b1  = m_busy;
    r_addr = m_addr;
    prev  = m_srclk;
    while (m_busy && r_cyc < 400) begin
      @(negedge clk);
      r_cyc++;
      if (m_srclk && !prev) begin
        r_rise++;
        r_data = {r_data[14:0], m_data};
        r_sel  = {r_sel[14:0], m_sel};
      end
      prev = m_srclk;
      if (m_rclk) r_rclk++;
      if (m_fd) r_fd++;
      tick = (r_cyc == t2) || (r_cyc == t3);
      if (r_cyc == en_off) en = 1'b0;
    end
    tick = 1'b0;
    check_eq("row_ends_in_budget", 32'(r_cyc < 400), 32'd1);
  endtask

  initial begin
    int cnt, bz;
    mem = '{16'hA5C3, 16'h0F0F, 16'h3C3C, 16'h1234, 16'h8001, 16'hFFFF, 16'h0000, 16'h5555,
            16'hAAAA, 16'h7E7E, 16'hC0DE, 16'hBEEF, 16'h0F1E, 16'h2D3C, 16'h4B5A, 16'h6978};
    clr0 = 1'b1; clr1 = 1'b1; en = 1'b0; tick = 1'b0; mon1 = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy0), 32'd0);
    check_eq("rst_srclk", 32'(bus0.srclk), 32'd0);
    check_eq("rst_rclk", 32'(bus0.rclk), 32'd0);
    check_eq("rst_ser", 32'({bus0.ser_data, bus0.ser_sel}), 32'd0);
    check_eq("rst_flags", 32'({fd0, ovr0}), 32'd0);
    check_eq("rst_addr", 32'(bus0.rd_addr), 32'd0);
    clr0 = 1'b0;
    en   = 1'b1;

    // Single row 0
    run_row(1'b1, 0, 0, 0);
    check_eq("t1_rises", 32'(r_rise), 32'd16);
    check_eq("t1_data", 32'(r_data), 32'h0000_A5C3);
    check_eq("t1_sel", 32'(r_sel), 32'h0000_0001);
    check_eq("t1_rclk_hi", 32'(r_rclk), 32'd2);
    check_eq("t1_latency", 32'(r_cyc), 32'd68);
    check_eq("t1_addr", 32'(r_addr), 32'd0);

    // Full frame plus wrap
    do_clr();
    for (int i = 0; i < 16; i++) begin
      run_row(1'b1, 0, 0, 0);
      check_eq("t2_addr", 32'(r_addr), 32'(i));
      check_eq("t2_data", 32'(r_data), 32'(mem[i]));
      check_eq("t2_frame_done", 32'(r_fd), (i == 15) ? 32'd1 : 32'd0);
    end
    run_row(1'b1, 0, 0, 0);
    check_eq("t2_wrap_addr", 32'(r_addr), 32'd0);
    check_eq("t2_wrap_fd", 32'(r_fd), 32'd0);

    // Pending tick and overrun
    do_clr();
    run_row(1'b1, 10, 20, 0);
    check_eq("t3_overrun_set", 32'(ovr0), 32'd1);
    run_row(1'b0, 0, 0, 0);
    check_eq("t3_pending_served", 32'(r_b1), 32'd1);
    check_eq("t3_pending_addr", 32'(r_addr), 32'd1);
    check_eq("t3_pending_rises", 32'(r_rise), 32'd16);
    check_eq("t3_overrun_sticky", 32'(ovr0), 32'd1);
    do_clr();
    check_eq("t3_overrun_clr", 32'(ovr0), 32'd0);

    // Tick coinciding with row completion
    run_row(1'b1, 67, 0, 0);
    run_row(1'b0, 0, 0, 0);
    check_eq("t3_edge_served", 32'(r_b1), 32'd1);
    check_eq("t3_edge_addr", 32'(r_addr), 32'd1);
    check_eq("t3_edge_ovr", 32'(ovr0), 32'd0);

    // clr mid-shift at bit 7 of row 1
    do_clr();
    run_row(1'b1, 0, 0, 0);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (31) @(negedge clk);
    check_eq("t4_pre_srclk", 32'(bus0.srclk), 32'd1);
    check_eq("t4_pre_data", 32'(bus0.ser_data), 32'd1);
    clr0 = 1'b1;
    #1;
    check_eq("t4_srclk", 32'(bus0.srclk), 32'd0);
    check_eq("t4_rclk", 32'(bus0.rclk), 32'd0);
    check_eq("t4_ser", 32'({bus0.ser_data, bus0.ser_sel}), 32'd0);
    check_eq("t4_busy", 32'(busy0), 32'd0);
    @(negedge clk); clr0 = 1'b0;
    run_row(1'b1, 0, 0, 0);
    check_eq("t4_restart_addr", 32'(r_addr), 32'd0);
    check_eq("t4_restart_rises", 32'(r_rise), 32'd16);
    check_eq("t4_restart_data", 32'(r_data), 32'h0000_A5C3);

    // en gating
    en = 1'b0; cnt = 0; bz = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      tick = (i % 8 == 0);
      if (m_srclk) cnt++;
      if (m_busy) bz++;
    end
    tick = 1'b0;
    check_eq("t5_en0_srclk", 32'(cnt), 32'd0);
    check_eq("t5_en0_busy", 32'(bz), 32'd0);
    en = 1'b1;
    run_row(1'b1, 10, 0, 20);
    check_eq("t5_enoff_rclk", 32'(r_rclk), 32'd2);
    run_row(1'b0, 0, 0, 0);
    check_eq("t5_old_pending", 32'(r_b1), 32'd1);
    check_eq("t5_old_pending_rises", 32'(r_rise), 32'd16);
    en = 1'b1;
    run_row(1'b1, 30, 0, 20);
    check_eq("t5_finish_rises", 32'(r_rise), 32'd16);
    check_eq("t5_finish_rclk", 32'(r_rclk), 32'd2);
    bz = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_busy) bz++;
    end
    check_eq("t5_no_more_rows", 32'(bz), 32'd0);

    // Active-low row select on dut1
    mon1 = 1'b1;
    en   = 1'b1;
    do_clr();
    for (int i = 0; i < 4; i++) begin
      run_row(1'b1, 0, 0, 0);
      if (i == 0) check_eq("t6_row0_sel", 32'(r_sel), 32'h0000_FFFE);
    end
    check_eq("t6_addr", 32'(r_addr), 32'd3);
    check_eq("t6_sel", 32'(r_sel), 32'h0000_FFF7);
    check_eq("t6_data", 32'(r_data), 32'h0000_1234);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/matrix_scan_ctrl.md
Name: matrix_scan_ctrl

Overview:
- Row-scan controller for the 16x16 LED matrix, which is driven by cascaded '595 shift registers.
- On each row tick it fetches one row word from the frame buffer and builds the one-hot row-select word.
- It shifts both words out in parallel on two serial lines, sharing one SRCLK, then pulses RCLK to latch them.
- It sits between the game-state frame buffer and the ARDUINO_IO pins, and replaces ad-hoc counter-based SRCLK/RCLK generation.

Parameters:
- N_ROWS, 16, matrix rows (power of two).
- N_COLS, 16, bits shifted per row.
- DIV, 25, clk cycles per SRCLK half-period; also the RCLK high time (>=1).
- SEL_ACTIVE_LOW, 0, 1 inverts the row-select word before shifting.

Ports:
- clk, input, 1: system clock (50 MHz).
- clr, input, 1: asynchronous active-high reset.
- en, input, 1: scan enable; gates acceptance of row_tick.
- row_tick, input, 1: one-cycle strobe requesting the next row (ENCOUNT output, 1 ms).
- rd_addr, output, log2(N_ROWS): frame-buffer row address.
- rd_data, input, N_COLS: frame-buffer row word; valid the cycle after rd_addr is presented.
- ser_data, output, 1: serial pixel data.
- ser_sel, output, 1: serial row-select data.
- srclk, output, 1: shift clock.
- rclk, output, 1: storage latch clock.
- busy, output, 1: high whenever state != IDLE.
- frame_done, output, 1: one-cycle pulse after the last row is latched.
- overrun, output, 1: sticky flag; row_tick arrived while busy with a tick already pending.

Behaviour:
- Reset (async, clr=1): state IDLE; row=0; pending=0; all outputs 0.
- IDLE:
  - Start condition is (row_tick & en) or pending; pending clears on start.
  - On start: drive rd_addr=row and go to FETCH.
- FETCH (1 cycle):
  - Capture data_sr<=rd_data.
  - Capture sel_sr<=one-hot(row); bit[row]=1, inverted if SEL_ACTIVE_LOW.
  - Clear bit counter; go to SHIFT.
- SHIFT, per bit, MSB (bit N_COLS-1) first:
  - ser_data/ser_sel present the current MSB while srclk=0 for DIV cycles.
  - srclk=1 for DIV cycles; data is held stable throughout.
  - On srclk falling back to 0, both registers shift left and the bit counter increments.
  - After N_COLS bits, go to LATCH with srclk=0.
- LATCH:
  - rclk=1 for DIV cycles; ser_data/ser_sel=0.
  - Then rclk=0, row<=row+1 (wraps N_ROWS-1 -> 0), go to IDLE.
  - frame_done=1 in the cycle row wraps to 0.
- Row latency, tick to rclk falling: 1 + 1 + 2*DIV*N_COLS + DIV cycles. At defaults this is 827 cycles.
- Tick while busy:
  - en=1 and pending=0: set pending.
  - en=1 and pending=1: overrun<=1; the tick is dropped.
- en deasserted mid-row: the current row completes; no further rows start. A pending tick from before en fell is still served.
- row_tick and row completion in the same cycle: the tick is recorded as pending; no loss.
- clr mid-SHIFT/LATCH: immediate return to reset values. The partial row is abandoned and row restarts at 0.
- Counters are sized to clog2 of their maxima. There is no arithmetic beyond increment and wrap.

Decomposition:
- Shared package:
  - scan_state_t enum (IDLE, FETCH, SHIFT, LATCH).
  - ROW_W=clog2(N_ROWS) and BIT_W=clog2(N_COLS+1) constants.
  - Pin index constants for ARDUINO_IO mapping (9 data, 10 sel, 11 srclk, 12 rclk).
- One sub-module, hc595_shifter: holds the two parallel shift registers, the bit counter and the DIV half-period timer. It takes a load strobe and data words, and returns a done strobe. The FSM, row counter, pending/overrun logic and RCLK timing stay in matrix_scan_ctrl.

Test Plan (DIV=2 unless noted):
1. Reset release, en=1, a single row_tick with rd_data=16'hA5C3 at row 0:
   - Exactly 16 srclk rising edges.
   - ser_data sampled at those edges = 1010010111000011.
   - ser_sel = 15 zeros then 1.
   - rclk high for 2 cycles; busy low after 1+1+64+2 cycles; rd_addr=0.
2. 16 spaced ticks:
   - rd_addr sequence is 0..15.
   - frame_done pulses exactly once, after row 15 latches.
   - The 17th tick uses row 0.
3. Tick during SHIFT, then a third tick:
   - The second tick is served immediately after LATCH (busy does not drop for more than 1 cycle).
   - The third tick, issued while the second is pending, sets overrun=1, which stays set until clr.
4. clr asserted in mid-SHIFT, bit 7:
   - Same cycle: srclk, rclk, ser_*, busy = 0.
   - Next tick restarts at rd_addr=0 with a full 16-bit shift.
5. en=0 ticks are ignored:
   - No srclk edges; busy stays 0.
   - en falling mid-row lets that row finish with rclk pulsed, and no further rows start.
6. SEL_ACTIVE_LOW=1, row 3: ser_sel shifted sequence = 1111111111110111; ser_data is unaffected.
